// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into IMEM words and holds the CPU until the load ends; optional checksum via IMEM_LOAD_CHECKSUM_EN
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [15:0]           load_len,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold
);
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef IMEM_LOAD_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;
    localparam logic [15:0] MAX_LEN = 16'(DEPTH);
    state_t state, state_nx;
    logic [15:0] len, cnt;
    logic [1:0] bidx;
    logic [DATA_WIDTH-1:0] word, word_nx;
    logic accept, start_ok;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`endif
    assign accept   = in_valid && in_ready;
    assign word_nx  = {word[DATA_WIDTH-9:0], in_data};
    assign start_ok = load_start && (state == IDLE || state == DONE);
    assign waddr    = cnt[ADDR_WIDTH-1:0];
    assign wdata    = word;
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // Next state and state-decoded outputs
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        we       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            IDLE, DONE: begin
                done     = state == DONE;
                cpu_hold = !(state == DONE && !err);
                if (load_start)
                    state_nx = (load_len == 16'd0 || load_len > MAX_LEN) ? DONE : COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && bidx == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                state_nx = (cnt + 16'd1 == len) ? CHECK : COLLECT;
`else
                state_nx = (cnt + 16'd1 == len) ? DONE : COLLECT;
`endif
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && bidx == 2'd3) state_nx = DONE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end
    // Load parameters, byte assembly, word counter and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len  <= '0;
            cnt  <= '0;
            bidx <= '0;
            word <= '0;
            err  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum  <= '0;
`endif
        end else begin
            if (start_ok) begin
                len  <= load_len;
                cnt  <= '0;
                bidx <= '0;
                word <= '0;
                err  <= load_len > MAX_LEN;
`ifdef IMEM_LOAD_CHECKSUM_EN
                sum  <= '0;
`endif
            end
            if (accept) begin
                word <= word_nx;
                bidx <= bidx + 2'd1;
            end
            if (state == WRITE) begin
                cnt <= cnt + 16'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                sum <= sum + word;
`endif
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (state == CHECK && accept && bidx == 2'd3) err <= (sum + word_nx) != '0;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with random byte streams and handshake patterns
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] load_len = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, we, busy, done, err, cpu_hold;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int checks = 0, errors = 0, nwrites = 0;
    logic [36:0] sb[$];
    logic [7:0]  stream[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .cpu_hold(cpu_hold)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every IMEM write must match the next expected word
    always @(negedge clk) begin : mon
        logic [36:0] e;
        if (rst_n && we) begin
            nwrites++;
            check("in_ready_in_write", {31'd0, in_ready}, 32'd0);
            if (sb.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("waddr", {27'd0, waddr}, {27'd0, e[36:32]});
                check("wdata", wdata, e[31:0]);
            end
        end
    end

    task automatic start_load(input int len);
        load_len = 16'(len);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send(input int mode, input int n);
        int i = 0, guard = 0;
        logic acc;
        while (i < n && guard < 5000) begin
            in_data = stream[i];
            in_valid = mode == 0 ? 1'b1 : mode == 1 ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (i < n) check("send_timeout", i, n);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("done", {31'd0, done}, 32'd1);
    endtask

    task automatic fill_random(input int n);
        stream.delete();
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    // Expected words come straight from the byte stream: word i = bytes 4i..4i+3, first byte MSB
    task automatic run(input int len, input int mode, input int bad_ck, input int poke);
        logic [31:0] w, sum, ck;
        logic exp_err;
        int w0;
        sum = '0;
        for (int i = 0; i < len; i++) begin
            w = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
            sb.push_back({5'(i), w});
            sum += w;
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        ck = (32'd0 - sum) + (bad_ck != 0 ? 32'd1 : 32'd0);
        for (int b = 3; b >= 0; b--) stream.push_back(8'(ck >> (8 * b)));
        exp_err = bad_ck != 0;
`else
        ck = '0;
        exp_err = 1'b0;
`endif
        w0 = nwrites;
        start_load(len);
        if (poke != 0) start_load(0);
        send(mode, stream.size());
        wait_done();
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
        check("busy_done", {31'd0, busy}, 32'd0);
        check("write_count", nwrites - w0, len);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int w0, len;
        logic [31:0] w;
        repeat (2) @(negedge clk);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_waddr", {27'd0, waddr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run(2, 0, 0, 0);

        fill_random(1);
        run(1, 1, 0, 1);

        w0 = nwrites;
        start_load(33);
        check("over_done", {31'd0, done}, 32'd1);
        check("over_err", {31'd0, err}, 32'd1);
        check("over_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        start_load(0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_err", {31'd0, err}, 32'd0);
        check("zero_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (3) @(negedge clk);
        check("len_edge_no_write", nwrites - w0, 0);

        fill_random(2);
        w = {stream[0], stream[1], stream[2], stream[3]};
        sb.push_back({5'd0, w});
        w0 = nwrites;
        start_load(2);
        send(0, 6);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_writes", nwrites - w0, 1);
        check("abort_sb", sb.size(), 0);
        check("abort_done", {31'd0, done}, 32'd0);
        fill_random(1);
        run(1, 0, 0, 0);

`ifdef IMEM_LOAD_CHECKSUM_EN
        stream = '{8'h00, 8'h00, 8'h00, 8'h01};
        run(1, 0, 0, 0);
        stream = '{8'h00, 8'h00, 8'h00, 8'h01};
        run(1, 0, 1, 0);
`endif

        for (int t = 0; t < 6; t++) begin
            len = (t == 0) ? 32 : int'($urandom_range(1, 32));
            fill_random(len);
            run(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
